decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/pipes_pkg.sv | 66 ++++++
 rtl/decode_stage_decoder.sv | 86 ++++++++
 rtl/decode_stage.sv | 72 +++++++
 3 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types: ALU operations, operand-A select, opcodes and the decoded bundle.
package pipes_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_LS   = 4'd2,
    ALU_RS   = 4'd3,
    ALU_SRS  = 4'd4,
    ALU_SCMP = 4'd5,
    ALU_CMP  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alufunc_t;

  typedef enum logic [1:0] {
    SRCA_REG  = 2'd0,
    SRCA_ZERO = 2'd1,
    SRCA_PC   = 2'd2
  } srca_t;

  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;

  typedef struct packed {
    alufunc_t    alufunc;
    srca_t       srca_sel;
    logic        srcb_imm;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        wordop;
    logic        illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '{
    alufunc: ALU_ADD, srca_sel: SRCA_REG, srcb_imm: 1'b0, imm: 64'd0,
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, regwrite: 1'b0, wordop: 1'b0, illegal: 1'b0
  };

  // funct3 to ALU operation for the register/immediate integer groups.
  function automatic alufunc_t f3_alu(input logic [2:0] f3);
    alufunc_t a;
    a = ALU_ADD;
    case (f3)
      3'd0: a = ALU_ADD;
      3'd1: a = ALU_LS;
      3'd2: a = ALU_SCMP;
      3'd3: a = ALU_CMP;
      3'd4: a = ALU_XOR;
      3'd5: a = ALU_RS;
      3'd6: a = ALU_OR;
      3'd7: a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// Combinational RV64I integer decoder. Word ops (OP-32/OP-IMM-32) are decoded
// only when DECODE_WORD_OPS_EN is defined; otherwise they fall out as illegal.
module decoder
  import pipes_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec          = DECODED_RESET;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    legal        = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.alufunc = f3_alu(f3);
        if (f7 == 7'h20 && f3 == 3'd0)      dec.alufunc = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) dec.alufunc = ALU_SRS;
        else if (f7 != 7'h00)               legal = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.alufunc  = f3_alu(f3);
        dec.srcb_imm = 1'b1;
        dec.imm      = {{52{instr[31]}}, instr[31:20]};
        if (f3 == 3'd1 || f3 == 3'd5) begin
          // Shifts carry the 6-bit shamt only; the upper field selects SRAI.
          dec.imm = {58'd0, instr[25:20]};
          if (f3 == 3'd5 && instr[31:26] == 6'b010000) dec.alufunc = ALU_SRS;
          else if (instr[31:26] != 6'd0)               legal = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.alufunc  = ALU_ADD;
        dec.srca_sel = (opcode == OPC_LUI) ? SRCA_ZERO : SRCA_PC;
        dec.srcb_imm = 1'b1;
        dec.imm      = {{32{instr[31]}}, instr[31:12], 12'd0};
      end
`ifdef DECODE_WORD_OPS_EN
      OPC_OP_32: begin
        dec.wordop = 1'b1;
        if (f3 == 3'd0 && f7 == 7'h00)      dec.alufunc = ALU_ADD;
        else if (f3 == 3'd0 && f7 == 7'h20) dec.alufunc = ALU_SUB;
        else if (f3 == 3'd1 && f7 == 7'h00) dec.alufunc = ALU_LS;
        else if (f3 == 3'd5 && f7 == 7'h00) dec.alufunc = ALU_RS;
        else if (f3 == 3'd5 && f7 == 7'h20) dec.alufunc = ALU_SRS;
        else                                legal = 1'b0;
      end
      OPC_OP_IMM_32: begin
        dec.wordop   = 1'b1;
        dec.srcb_imm = 1'b1;
        dec.imm      = {59'd0, instr[24:20]};
        if (f3 == 3'd0) begin
          dec.alufunc = ALU_ADD;
          dec.imm     = {{52{instr[31]}}, instr[31:20]};
        end
        else if (f3 == 3'd1 && f7 == 7'h00) dec.alufunc = ALU_LS;
        else if (f3 == 3'd5 && f7 == 7'h00) dec.alufunc = ALU_RS;
        else if (f3 == 3'd5 && f7 == 7'h20) dec.alufunc = ALU_SRS;
        else                                legal = 1'b0;
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alufunc  = ALU_ADD;
      dec.srca_sel = SRCA_REG;
      dec.srcb_imm = 1'b0;
      dec.imm      = 64'd0;
      dec.wordop   = 1'b0;
    end
    dec.illegal  = !legal;
    dec.regwrite = legal && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one output register with valid/ready handshake and flush.
// Word-op decoding is enabled by defining DECODE_WORD_OPS_EN.
module decode_stage
  import pipes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_instr,
  input  logic [63:0] f_pc,
  output logic        d_ready,
  output logic        e_valid,
  input  logic        e_ready,
  input  logic        flush,
  output alufunc_t    alufunc,
  output srca_t       srca_sel,
  output logic        srcb_imm,
  output logic [63:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        regwrite,
  output logic        wordop,
  output logic        illegal,
  output logic [63:0] e_pc
);

  decoded_t    dec;
  decoded_t    bundle_reg;
  logic [63:0] pc_reg;
  logic        e_valid_reg;
  logic        capture;

  decoder u_decoder (
    .instr (f_instr),
    .dec   (dec)
  );

  assign d_ready = !e_valid_reg || e_ready;
  assign capture = f_valid && d_ready && !flush;

  // Reset beats flush, flush beats capture; the bundle only moves on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_reg <= 1'b0;
      bundle_reg  <= DECODED_RESET;
      pc_reg      <= 64'd0;
    end else if (flush) begin
      e_valid_reg <= 1'b0;
    end else if (capture) begin
      e_valid_reg <= 1'b1;
      bundle_reg  <= dec;
      pc_reg      <= f_pc;
    end else if (e_ready) begin
      e_valid_reg <= 1'b0;
    end
  end

  assign e_valid  = e_valid_reg;
  assign alufunc  = bundle_reg.alufunc;
  assign srca_sel = bundle_reg.srca_sel;
  assign srcb_imm = bundle_reg.srcb_imm;
  assign imm      = bundle_reg.imm;
  assign rs1      = bundle_reg.rs1;
  assign rs2      = bundle_reg.rs2;
  assign rd       = bundle_reg.rd;
  assign regwrite = bundle_reg.regwrite;
  assign wordop   = bundle_reg.wordop;
  assign illegal  = bundle_reg.illegal;
  assign e_pc     = pc_reg;

endmodule
